// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - sequential argmax over the first NUM_CLASS signed score lanes (optional ARGMAX_OVERRUN_EN sticky overrun flag)
module argmax_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16,
    parameter int NUM_CLASS  = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [LANES*DATA_WIDTH-1:0] din_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [3:0]                  class_o,
    output logic [DATA_WIDTH-1:0]       score_o,
    output logic                        overrun_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value of the last lane that takes part in the scan.
    localparam logic [3:0] LAST_LANE = 4'(NUM_CLASS - 1);

    logic [1:0]                  state_q, state_d;
    logic [LANES*DATA_WIDTH-1:0] vec_q, vec_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic [3:0]                  idx_q, idx_d;
    logic [3:0]                  class_q, class_d;
    logic [DATA_WIDTH-1:0]       score_q, score_d;

    logic signed [DATA_WIDTH-1:0] lane_a [LANES];
    logic signed [DATA_WIDTH-1:0] lane_cur;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_a[g] = vec_q[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign lane_cur = lane_a[cnt_q];

    // Next-state logic: latch vector, walk lanes keeping the first strict maximum, publish result on DONE entry.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        class_d = class_q;
        score_d = score_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    vec_d   = din_i;
                    best_d  = din_i[DATA_WIDTH-1:0];
                    idx_d   = 4'd0;
                    cnt_d   = 4'd1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strictly greater only, so equal scores keep the lower index.
                if (lane_cur > best_q) begin
                    best_d = lane_cur;
                    idx_d  = cnt_q;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_LANE) begin
                    class_d = idx_d;
                    score_d = best_d;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any valid_i in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            class_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            class_q <= class_d;
            score_q <= score_d;
        end
    end

`ifdef ARGMAX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky flag: any valid_i seen outside IDLE was dropped.
    always_comb begin
        overrun_d = overrun_q | (valid_i & (state_q != S_IDLE));
    end

    // Overrun register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign class_o = class_q;
    assign score_o = score_q;

endmodule

// File: tb/tb_argmax_unit.sv
// tb/tb_argmax_unit.sv - directed self-checking bench for argmax_unit
module tb_argmax_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [127:0] din_i;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   class_o;
    logic [7:0]   score_o;
    logic         overrun_o;

    int errors = 0;
    int checks = 0;

    argmax_unit dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .din_i     (din_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .class_o   (class_o),
        .score_o   (score_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack16(input int a[16]);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k*8 +: 8] = a[k][7:0];
        end
        return r;
    endfunction

    // Starts a scan at the current negedge and returns at the negedge of the done cycle.
    // lat counts negedges after the valid edge (done expected at 10).
    // mode 0: plain, 1: scramble din every cycle, 2: extra valid at cycle 4, 3: reset at cycle 5.
    task automatic scan(input logic [127:0] vec, input logic [127:0] alt, input int mode,
                        output int lat, output int busy_cnt, output int held);
        logic [3:0] c0;
        logic [7:0] s0;
        c0 = class_o;
        s0 = score_o;
        held = 1;
        din_i   = vec;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i  = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        forever begin
            if (busy_o) busy_cnt++;
            if (done_o || lat >= 40) break;
            if (class_o !== c0 || score_o !== s0) held = 0;
            if (mode == 1) din_i = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 2 && lat == 4) begin
                din_i   = alt;
                valid_i = 1'b1;
            end
            if (mode == 2 && lat == 5) valid_i = 1'b0;
            if (mode == 3 && lat == 5) rst_i = 1'b1;
            if (mode == 3 && lat == 6) begin
                rst_i = 1'b0;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, held, exp_ovr;
        logic [127:0] v;
        logic [127:0] w;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        din_i   = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_class", class_o, 0);
        check("rst_score", score_o, 0);
        check("rst_overrun", overrun_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Tie at 12 on lanes 2 and 4 resolves to lane 2.
        v = pack16('{3, -7, 12, 5, 12, 0, -1, 8, 1, 2, 100, 100, 100, 100, 100, 100});
        scan(v, '0, 0, lat, bc, held);
        check("tie_latency", lat, 10);
        check("tie_busy_cycles", bc, 10);
        check("tie_hold", held, 1);
        check("tie_class", class_o, 2);
        check("tie_score", $signed(score_o), 12);
        @(negedge clk_i);
        check("tie_done_width", done_o, 0);
        check("tie_idle_busy", busy_o, 0);
        check("tie_class_held", class_o, 2);

        // Signed compare and upper-lane exclusion.
        v = pack16('{-128, -128, -128, -128, -128, -128, -128, -128, -128, -127,
                     127, 127, 127, 127, 127, 127});
        scan(v, '0, 0, lat, bc, held);
        check("neg_latency", lat, 10);
        check("neg_class", class_o, 9);
        check("neg_score", $signed(score_o), -127);
        @(negedge clk_i);

        // Back-to-back: second valid in the cycle after done -> pulses 11 cycles apart.
        v = pack16('{0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        scan(v, '0, 0, lat, bc, held);
        check("b2b_first_class", class_o, 4);
        check("b2b_first_score", $signed(score_o), 50);
        @(negedge clk_i);
        check("b2b_gap_done", done_o, 0);
        v = pack16('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        scan(v, '0, 0, lat, bc, held);
        check("b2b_second_gap", lat + 1, 11);
        check("b2b_second_class", class_o, 0);
        check("b2b_second_score", $signed(score_o), 1);
        @(negedge clk_i);

        // Valid during scan is dropped.
        v = pack16('{0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0});
        w = pack16('{0, 90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        scan(v, w, 2, lat, bc, held);
        check("ovr_latency", lat, 10);
        check("ovr_class", class_o, 7);
        check("ovr_score", $signed(score_o), 20);
`ifdef ARGMAX_OVERRUN_EN
        exp_ovr = 1;
`else
        exp_ovr = 0;
`endif
        check("ovr_flag", overrun_o, exp_ovr);
        @(negedge clk_i);
        check("ovr_no_second_done", done_o, 0);
        check("ovr_idle", busy_o, 0);

        // Reset mid-scan aborts with no done pulse.
        v = pack16('{0, 0, 0, 0, 0, 0, 0, 0, 33, 0, 0, 0, 0, 0, 0, 0});
        scan(v, '0, 3, lat, bc, held);
        check("rstmid_stop_cycle", lat, 6);
        check("rstmid_done", done_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_class", class_o, 0);
        check("rstmid_score", score_o, 0);
        check("rstmid_overrun", overrun_o, 0);
        repeat (12) begin
            @(negedge clk_i);
            check("rstmid_quiet", done_o, 0);
        end

        // din_i churn after the valid cycle must not matter.
        v = pack16('{-5, 10, 60, 77, -90, 76, 0, 77, 3, 4, 127, 127, 127, 127, 127, 127});
        scan(v, '0, 1, lat, bc, held);
        check("churn_latency", lat, 10);
        check("churn_hold", held, 1);
        check("churn_class", class_o, 3);
        check("churn_score", $signed(score_o), 77);
        @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/argmax_unit.md
ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one signed class score in bits.
REQ-002 Parameter LANES, default 16: number of score lanes on din_i.
REQ-003 Parameter NUM_CLASS, default 10: lanes 0..NUM_CLASS-1 are scanned; legal range 2..LANES.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  single-cycle pulse; din_i holds a complete final-layer result vector.
REQ-007 din_i  input  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH+DATA_WIDTH-1 : k*DATA_WIDTH], two's complement.
REQ-008 busy_o  output  1  high while a scan is in progress.
REQ-009 done_o  output  1  one-cycle pulse when class_o/score_o are updated.
REQ-010 class_o  output  4  index of the winning class.
REQ-011 score_o  output  DATA_WIDTH  signed score of the winning class.
REQ-012 overrun_o  output  1  sticky flag: valid_i arrived while busy (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, DONE; the reset state is IDLE.
REQ-014 IDLE: on valid_i=1, latch all of din_i into an internal vector register, load best score with lane 0, best index 0, lane counter 1, and go to SCAN.
REQ-015 SCAN: each cycle compare lane[counter] with best score using a signed compare; replace best score/index only when strictly greater, so ties resolve to the lowest index.
REQ-016 SCAN: the counter increments by 1 per cycle; after lane NUM_CLASS-1 is compared, go to DONE.
REQ-017 DONE: drive class_o/score_o from best index/score, pulse done_o for exactly one cycle, return to IDLE.
REQ-018 Latency: valid_i sampled in cycle 0 -> done_o high in cycle NUM_CLASS (10 with defaults); busy_o high in cycles 1..NUM_CLASS.
REQ-019 class_o and score_o SHALL hold their values between done_o pulses and SHALL change only in the done_o cycle.
REQ-020 Lanes NUM_CLASS..LANES-1 SHALL never influence the result.
REQ-021 valid_i while busy_o=1 or in the DONE cycle SHALL be ignored: latched vector and scan unaffected.
REQ-022 valid_i in the cycle after done_o SHALL start a new scan normally (back-to-back throughput one result per NUM_CLASS+1 cycles).
REQ-023 din_i SHALL be sampled only in the valid_i cycle; later changes on din_i do not affect the running scan.

Reset
REQ-024 rst_i=1 at a clock edge SHALL force IDLE, busy_o=0, done_o=0, class_o=0, score_o=0, overrun_o=0, counter=0, best registers=0.
REQ-025 rst_i asserted mid-scan SHALL abort the scan with no done_o pulse; rst_i has priority over valid_i in the same cycle.

Configuration
REQ-026 Macro ARGMAX_OVERRUN_EN defined: overrun_o sets to 1 on any valid_i ignored per REQ-021 and stays 1 until rst_i.
REQ-027 Macro ARGMAX_OVERRUN_EN undefined: the overrun logic is not built and overrun_o is constant 0; all other behaviour identical.

Verification
REQ-028 Lanes 0..9 = {3,-7,12,5,12,0,-1,8,1,2}, valid_i pulse -> done_o exactly 10 cycles later, class_o=2, score_o=12 (tie to lowest index).
REQ-029 All lanes -128 except lane 9=-127, lanes 10..15=127 -> class_o=9, score_o=-127 (upper lanes excluded, signed compare).
REQ-030 Two vectors, second valid_i the cycle after done_o (lane 4=50 max, then lane 0=1 with others 0) -> two done_o pulses 11 cycles apart, class_o 4 then 0.
REQ-031 valid_i at cycle 0 then again at cycle 4 with different data -> single done_o at cycle 10 with first vector's result; overrun_o=1 with ARGMAX_OVERRUN_EN, 0 without.
REQ-032 rst_i pulsed at cycle 5 of a scan -> no done_o, busy_o=0, class_o=0, score_o=0 next cycle; a fresh valid_i then completes normally.
REQ-033 din_i changed every cycle during a scan -> result matches the vector present in the valid_i cycle.
